// File: rtl/pc_seq_pkg.sv
// Shared types and default constants for the next-PC sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } state_t;

    typedef enum logic [2:0] {
        SRC_HOLD,
        SRC_IRQ,
        SRC_RET,
        SRC_JMP,
        SRC_BR,
        SRC_INC
    } src_t;

    localparam int unsigned DEFAULT_D_WIDTH      = 12;
    localparam int unsigned DEFAULT_STACK_DEPTH  = 4;
    localparam logic [11:0] DEFAULT_RESET_VECTOR = 12'h000;
    localparam logic [11:0] DEFAULT_IRQ_VECTOR   = 12'h004;

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO. A push while full and a pop while empty are ignored;
// the parent decides how to report those cases.
module pc_ret_stack #(
    parameter int unsigned D_WIDTH     = 12,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [D_WIDTH-1:0] push_data,
    output logic [D_WIDTH-1:0] top,
    output logic               full,
    output logic               empty
);

    localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
    localparam int unsigned SP_W  = IDX_W + 1;

    logic [SP_W-1:0]    sp;
    logic [D_WIDTH-1:0] mem [STACK_DEPTH];
    logic [IDX_W-1:0]   top_idx;
    logic [IDX_W-1:0]   wr_idx;

    assign full    = (sp == SP_W'(STACK_DEPTH));
    assign empty   = (sp == '0);
    assign top_idx = IDX_W'(sp - 1'b1);
    assign wr_idx  = IDX_W'(sp);
    assign top     = mem[top_idx];

    // Stack pointer and entry storage; a push takes precedence over a pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp <= '0;
            for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !full) begin
            mem[wr_idx] <= push_data;
            sp          <= sp + 1'b1;
        end else if (pop && !empty) begin
            sp <= sp - 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: BOOT/RUN/HALT FSM, prioritised next-PC select and
// sticky stack error flags in front of the program_counter register.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned        D_WIDTH      = DEFAULT_D_WIDTH,
    parameter int unsigned        STACK_DEPTH  = DEFAULT_STACK_DEPTH,
    parameter logic [D_WIDTH-1:0] RESET_VECTOR = D_WIDTH'(DEFAULT_RESET_VECTOR),
    parameter logic [D_WIDTH-1:0] IRQ_VECTOR   = D_WIDTH'(DEFAULT_IRQ_VECTOR)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [D_WIDTH-1:0] pc_cur,
    output logic [D_WIDTH-1:0] pc_next,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [D_WIDTH-1:0] branch_target,
    input  logic               jump,
    input  logic               call,
    input  logic [D_WIDTH-1:0] jump_target,
    input  logic               ret,
    input  logic               irq,
    input  logic               irq_en,
    output logic               irq_ack,
    input  logic               halt,
    input  logic               resume,
    output logic               halted,
    output logic               stk_overflow,
    output logic               stk_underflow
);

    state_t             state;
    state_t             state_next;
    src_t               src;
    logic               push;
    logic               pop;
    logic               set_unf;
    logic               irq_take;
    logic [D_WIDTH-1:0] push_data;
    logic [D_WIDTH-1:0] pc_inc;
    logic [D_WIDTH-1:0] stk_top;
    logic               stk_full;
    logic               stk_empty;

    assign pc_inc   = pc_cur + D_WIDTH'(1);
    assign irq_take = irq && irq_en && !stall;
    assign halted   = (state == HALT);

    pc_ret_stack #(
        .D_WIDTH     (D_WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // State register and sticky stack error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= BOOT;
            stk_overflow  <= 1'b0;
            stk_underflow <= 1'b0;
        end else begin
            state <= state_next;
            if (push && stk_full) begin
                stk_overflow <= 1'b1;
            end
            if (set_unf) begin
                stk_underflow <= 1'b1;
            end
        end
    end

    // Next state, source select and stack control in strict priority order.
    always_comb begin
        state_next = state;
        src        = SRC_INC;
        push       = 1'b0;
        pop        = 1'b0;
        push_data  = pc_inc;
        irq_ack    = 1'b0;
        set_unf    = 1'b0;
        case (state)
            BOOT: begin
                src        = SRC_HOLD;
                state_next = RUN;
            end
            RUN: begin
                if (stall) begin
                    src = SRC_HOLD;
                end else if (irq_take) begin
                    src       = SRC_IRQ;
                    push      = 1'b1;
                    push_data = pc_cur;
                    irq_ack   = 1'b1;
                end else if (halt) begin
                    src        = SRC_HOLD;
                    state_next = HALT;
                end else if (ret) begin
                    // Underflow falls through to sequential fetch.
                    if (stk_empty) begin
                        src     = SRC_INC;
                        set_unf = 1'b1;
                    end else begin
                        src = SRC_RET;
                        pop = 1'b1;
                    end
                end else if (call) begin
                    src  = SRC_JMP;
                    push = 1'b1;
                end else if (jump) begin
                    src = SRC_JMP;
                end else if (branch_taken) begin
                    src = SRC_BR;
                end
            end
            HALT: begin
                src = SRC_HOLD;
                if (irq_take) begin
                    src        = SRC_IRQ;
                    push       = 1'b1;
                    push_data  = pc_cur;
                    irq_ack    = 1'b1;
                    state_next = RUN;
                end else if (resume) begin
                    state_next = RUN;
                end
            end
            default: begin
                src        = SRC_HOLD;
                state_next = BOOT;
            end
        endcase
    end

    // Next-PC multiplexer; BOOT always presents the reset vector.
    always_comb begin
        pc_next = pc_inc;
        if (state == BOOT) begin
            pc_next = RESET_VECTOR;
        end else begin
            case (src)
                SRC_HOLD: pc_next = pc_cur;
                SRC_IRQ:  pc_next = IRQ_VECTOR;
                SRC_RET:  pc_next = stk_top;
                SRC_JMP:  pc_next = jump_target;
                SRC_BR:   pc_next = branch_target;
                SRC_INC:  pc_next = pc_inc;
                default:  pc_next = pc_inc;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer. Inputs change on the falling
// edge, combinational outputs are sampled 1 ns later, state commits on the
// following rising edge.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic [11:0] pc_cur;
    logic [11:0] pc_next;
    logic        stall;
    logic        branch_taken;
    logic [11:0] branch_target;
    logic        jump;
    logic        call;
    logic [11:0] jump_target;
    logic        ret;
    logic        irq;
    logic        irq_en;
    logic        irq_ack;
    logic        halt;
    logic        resume;
    logic        halted;
    logic        stk_overflow;
    logic        stk_underflow;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(
        .D_WIDTH      (12),
        .STACK_DEPTH  (4),
        .RESET_VECTOR (12'h000),
        .IRQ_VECTOR   (12'h004)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_cur        (pc_cur),
        .pc_next       (pc_next),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .call          (call),
        .jump_target   (jump_target),
        .ret           (ret),
        .irq           (irq),
        .irq_en        (irq_en),
        .irq_ack       (irq_ack),
        .halt          (halt),
        .resume        (resume),
        .halted        (halted),
        .stk_overflow  (stk_overflow),
        .stk_underflow (stk_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        stall = 0; branch_taken = 0; jump = 0; call = 0; ret = 0;
        irq = 0; irq_en = 0; halt = 0; resume = 0;
        branch_target = '0; jump_target = '0;
    endtask

    // Pass through the next rising edge and stop on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle();
        pc_cur = 12'h000;
        reset  = 0;
        #1;
        checks++; if (pc_next !== 12'h000) begin errors++; $display("FAIL rst_pc pc_next=%h expected=%h", pc_next, 12'h000); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got=%b expected=0", halted); end
        checks++; if (irq_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got=%b expected=0", irq_ack); end
        checks++; if (stk_overflow !== 1'b0 || stk_underflow !== 1'b0) begin errors++; $display("FAIL rst_flags got=%b%b expected=00", stk_overflow, stk_underflow); end
        #1 reset = 1;
        #1;
        checks++; if (pc_next !== 12'h000) begin errors++; $display("FAIL boot_pc pc_next=%h expected=%h", pc_next, 12'h000); end
        tick();
        pc_cur = 12'h000; #1;
        checks++; if (pc_next !== 12'h001) begin errors++; $display("FAIL inc0 pc_next=%h expected=%h", pc_next, 12'h001); end
        tick();
        pc_cur = 12'h001; #1;
        checks++; if (pc_next !== 12'h002) begin errors++; $display("FAIL inc1 pc_next=%h expected=%h", pc_next, 12'h002); end
        pc_cur = 12'hFFF; #1;
        checks++; if (pc_next !== 12'h000) begin errors++; $display("FAIL wrap pc_next=%h expected=%h", pc_next, 12'h000); end
        tick();
    endtask

    task automatic test_call_ret();
        idle();
        pc_cur = 12'h010; call = 1; jump_target = 12'h100; #1;
        checks++; if (pc_next !== 12'h100) begin errors++; $display("FAIL call_target pc_next=%h expected=%h", pc_next, 12'h100); end
        tick();
        idle();
        pc_cur = 12'h105; ret = 1; #1;
        checks++; if (pc_next !== 12'h011) begin errors++; $display("FAIL ret_addr pc_next=%h expected=%h", pc_next, 12'h011); end
        tick();
        idle();
    endtask

    task automatic test_nested_calls();
        logic [11:0] exp_pc;
        idle();
        for (int i = 0; i < 5; i++) begin
            pc_cur = 12'h040 + 12'(i);
            jump_target = 12'h100 + 12'(i * 16);
            call = 1; #1;
            checks++; if (pc_next !== jump_target) begin errors++; $display("FAIL nest_call%0d pc_next=%h expected=%h", i, pc_next, jump_target); end
            if (i == 4) begin
                checks++; if (stk_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b expected=0", stk_overflow); end
            end
            tick();
        end
        idle();
        #1;
        checks++; if (stk_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b expected=1", stk_overflow); end
        for (int i = 0; i < 4; i++) begin
            pc_cur = 12'h300 + 12'(i);
            ret = 1; #1;
            exp_pc = 12'h044 - 12'(i);
            checks++; if (pc_next !== exp_pc) begin errors++; $display("FAIL nest_ret%0d pc_next=%h expected=%h", i, pc_next, exp_pc); end
            tick();
        end
        checks++; if (stk_underflow !== 1'b0) begin errors++; $display("FAIL unf_early got=%b expected=0", stk_underflow); end
        pc_cur = 12'h310; ret = 1; #1;
        checks++; if (pc_next !== 12'h311) begin errors++; $display("FAIL unf_pc pc_next=%h expected=%h", pc_next, 12'h311); end
        tick();
        idle(); #1;
        checks++; if (stk_underflow !== 1'b1) begin errors++; $display("FAIL unf_set got=%b expected=1", stk_underflow); end
    endtask

    task automatic test_irq_stall();
        idle();
        pc_cur = 12'h060; irq = 1; irq_en = 0; #1;
        checks++; if (pc_next !== 12'h061 || irq_ack !== 1'b0) begin errors++; $display("FAIL irq_masked pc_next=%h ack=%b expected=061 0", pc_next, irq_ack); end
        tick();
        pc_cur = 12'h020; irq_en = 1; stall = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (pc_next !== 12'h020 || irq_ack !== 1'b0) begin errors++; $display("FAIL irq_stall%0d pc_next=%h ack=%b expected=020 0", i, pc_next, irq_ack); end
            tick();
        end
        stall = 0; #1;
        checks++; if (pc_next !== 12'h004 || irq_ack !== 1'b1) begin errors++; $display("FAIL irq_take pc_next=%h ack=%b expected=004 1", pc_next, irq_ack); end
        tick();
        idle();
        pc_cur = 12'h004; #1;
        checks++; if (pc_next !== 12'h005 || irq_ack !== 1'b0) begin errors++; $display("FAIL irq_after pc_next=%h ack=%b expected=005 0", pc_next, irq_ack); end
        tick();
        pc_cur = 12'h008; ret = 1; #1;
        checks++; if (pc_next !== 12'h020) begin errors++; $display("FAIL irq_ret pc_next=%h expected=%h", pc_next, 12'h020); end
        tick();
        idle();
    endtask

    task automatic test_halt();
        idle();
        pc_cur = 12'h030; halt = 1; call = 1; jump_target = 12'h3AA; #1;
        checks++; if (pc_next !== 12'h030) begin errors++; $display("FAIL halt_enter pc_next=%h expected=%h", pc_next, 12'h030); end
        tick();
        idle();
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (halted !== 1'b1 || pc_next !== 12'h030) begin errors++; $display("FAIL halt_hold%0d halted=%b pc_next=%h expected=1 030", i, halted, pc_next); end
            tick();
        end
        resume = 1; #1;
        tick();
        resume = 0; #1;
        checks++; if (halted !== 1'b0 || pc_next !== 12'h031) begin errors++; $display("FAIL resume halted=%b pc_next=%h expected=0 031", halted, pc_next); end
        pc_cur = 12'h031; halt = 1;
        tick();
        halt = 0; irq = 1; irq_en = 1; #1;
        checks++; if (halted !== 1'b1 || pc_next !== 12'h004 || irq_ack !== 1'b1) begin errors++; $display("FAIL halt_irq halted=%b pc_next=%h ack=%b expected=1 004 1", halted, pc_next, irq_ack); end
        tick();
        idle();
        pc_cur = 12'h004; #1;
        checks++; if (halted !== 1'b0 || pc_next !== 12'h005) begin errors++; $display("FAIL halt_irq_run halted=%b pc_next=%h expected=0 005", halted, pc_next); end
        pc_cur = 12'h006; ret = 1; #1;
        checks++; if (pc_next !== 12'h031) begin errors++; $display("FAIL halt_irq_ret pc_next=%h expected=%h", pc_next, 12'h031); end
        tick();
        idle();
    endtask

    task automatic test_priority();
        idle();
        pc_cur = 12'h050; call = 1; jump_target = 12'h060; #1;
        tick();
        idle();
        pc_cur = 12'h060; call = 1; ret = 1; branch_taken = 1;
        jump_target = 12'h070; branch_target = 12'h080; #1;
        checks++; if (pc_next !== 12'h051) begin errors++; $display("FAIL prio_ret pc_next=%h expected=%h", pc_next, 12'h051); end
        tick();
        idle();
        pc_cur = 12'h0C0; ret = 1; #1;
        checks++; if (pc_next !== 12'h0C1) begin errors++; $display("FAIL prio_no_push pc_next=%h expected=%h", pc_next, 12'h0C1); end
        tick();
        idle();
        pc_cur = 12'h0C8; jump = 1; branch_taken = 1; jump_target = 12'h2A0; branch_target = 12'h2B0; #1;
        checks++; if (pc_next !== 12'h2A0) begin errors++; $display("FAIL prio_jump pc_next=%h expected=%h", pc_next, 12'h2A0); end
        jump = 0; #1;
        checks++; if (pc_next !== 12'h2B0) begin errors++; $display("FAIL branch pc_next=%h expected=%h", pc_next, 12'h2B0); end
        tick();
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        for (int i = 0; i < 3; i++) begin
            pc_cur = 12'h0D0 + 12'(i); call = 1; jump_target = 12'h200; #1;
            tick();
        end
        idle();
        pc_cur = 12'h200; ret = 1;
        #2 reset = 0;
        #1;
        checks++; if (pc_next !== 12'h000) begin errors++; $display("FAIL mid_rst_pc pc_next=%h expected=%h", pc_next, 12'h000); end
        checks++; if (stk_overflow !== 1'b0 || stk_underflow !== 1'b0) begin errors++; $display("FAIL mid_rst_flags got=%b%b expected=00", stk_overflow, stk_underflow); end
        tick();
        idle();
        reset = 1;
        tick();
        pc_cur = 12'h0E0; ret = 1; #1;
        checks++; if (pc_next !== 12'h0E1) begin errors++; $display("FAIL mid_rst_empty pc_next=%h expected=%h", pc_next, 12'h0E1); end
        tick();
        idle(); #1;
        checks++; if (stk_underflow !== 1'b1) begin errors++; $display("FAIL mid_rst_unf got=%b expected=1", stk_underflow); end
    endtask

    initial begin
        test_reset();
        test_call_ret();
        test_nested_calls();
        test_irq_stall();
        test_halt();
        test_priority();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Next-PC controller for the pico processor's program_counter register. Each cycle it selects the value driven onto the counter's pc_in from these sources: increment, branch, jump, call/return stack, interrupt vector, and hold (stall/halt). It sits between decode/execute and the PC register. The PC register itself stays a plain D-register; all sequencing lives here.

Parameters:
D_WIDTH, 12, PC/address width (matches program_counter d_width)
STACK_DEPTH, 4, return-address stack entries (power of 2, >=2)
RESET_VECTOR, 12'h000, first fetch address after reset
IRQ_VECTOR, 12'h004, interrupt entry address

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
pc_cur  in  D_WIDTH  current PC (program_counter pc_out)
pc_next  out  D_WIDTH  next PC (to program_counter pc_in), combinational
stall  in  1  hold PC this cycle (pipeline bubble)
branch_taken  in  1  conditional branch resolved taken
branch_target  in  D_WIDTH  branch destination
jump  in  1  unconditional jump
call  in  1  jump and push return address
jump_target  in  D_WIDTH  destination for jump/call
ret  in  1  pop return address
irq  in  1  level interrupt request
irq_en  in  1  global interrupt enable
irq_ack  out  1  one-cycle pulse: vector taken this cycle
halt  in  1  enter HALT
resume  in  1  leave HALT
halted  out  1  high while in HALT
stk_overflow  out  1  sticky: call with full stack
stk_underflow  out  1  sticky: ret with empty stack

Behaviour:
- Async reset (reset==0): state=BOOT, sp=0, stack entries=0, stk_overflow=0, stk_underflow=0, halted=0, irq_ack=0. pc_next=RESET_VECTOR while in BOOT.
- FSM states are BOOT, RUN and HALT.
  - BOOT -> RUN unconditionally on the first clk edge after reset release.
  - RUN -> HALT when halt=1 and stall=0 (takes precedence over all other sources except irq).
  - HALT -> RUN on resume=1, or on irq&irq_en=1.
- pc_next in RUN, as a strict priority (first match wins):
  1. stall=1: pc_cur; nothing pushed or popped; irq_ack=0; irq stays pending.
  2. irq&irq_en: IRQ_VECTOR; push pc_cur (the interrupted instruction is re-executed on ret); irq_ack=1.
  3. halt: pc_cur.
  4. ret: top of stack; sp--.
  5. call: jump_target; push pc_cur+1.
  6. jump: jump_target.
  7. branch_taken: branch_target.
  8. otherwise: pc_cur+1.
- pc_next in HALT: pc_cur; irq&irq_en gives IRQ_VECTOR with push and irq_ack as in RUN.
- Latency: pc_next is valid in the same cycle as the request; program_counter captures it on the next edge. Stack push/pop and flag updates happen on that same edge.
- Arithmetic: pc_cur+1 is modulo 2^D_WIDTH, so all-ones wraps to 0 with no flag.
- Stack is LIFO with sp in 0..STACK_DEPTH.
  - Push when full: write dropped, sp unchanged, stk_overflow<=1, redirect still taken.
  - Pop when empty: pc_next=pc_cur+1, sp unchanged, stk_underflow<=1.
  - Sticky flags clear only on reset.
- Simultaneous lower-priority requests are ignored with no side effects (e.g. call+ret gives ret only).
- irq_ack is combinational and never asserted with stall=1.
- Reset mid-operation clears the stack immediately; no pending push/pop completes.

Decomposition:
- Package pc_seq_pkg holds:
  - FSM state encoding (BOOT/RUN/HALT);
  - next-PC source select enum (SRC_HOLD, SRC_IRQ, SRC_RET, SRC_JMP, SRC_BR, SRC_INC);
  - default vector constants.
- Sub-module pc_ret_stack: STACK_DEPTH x D_WIDTH LIFO with push, pop, push_data, top, full, empty, and async active-low reset. The top level keeps the FSM, priority mux and flags.

Test Plan:
- Reset release with pc_cur=0, no requests: cycle 0 pc_next=000, then 001, 002... Set pc_cur=FFF: pc_next=000.
- Call at pc_cur=010 with jump_target=100, then ret at pc_cur=105: pc_next 100 then 011; sp returns to 0.
- Five nested calls (STACK_DEPTH=4): the fifth redirects but sets stk_overflow=1. Four rets return the first four addresses. A further ret gives pc_cur+1 and sets stk_underflow=1.
- irq=1, irq_en=1 with stall=1 for 2 cycles, then stall=0 at pc_cur=020: pc_next=020 while stalled, irq_ack=0. Then pc_next=004 and irq_ack=1 for one cycle. A later ret returns 020.
- halt at pc_cur=030: halted=1 and pc_next=030 for 5 cycles. resume gives 031; or irq&irq_en while halted gives 004 and irq_ack=1.
- Same-cycle call+ret+branch_taken: only the pop occurs. Assert reset mid-sequence with sp=3: sp=0, flags=0, pc_next=RESET_VECTOR asynchronously.
